// File: rtl/dcache_assoc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_assoc_controller_pkg
// Purpose  : Shared definitions for the set-associative data cache controller:
//            FSM state encoding and the width helpers used to derive the
//            offset, index, tag and age field widths from the parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dcache_assoc_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FILL   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Ceiling log2; log2c(1) = 0.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Age / way-index width: never narrower than one bit, even when direct-mapped.
  function automatic int age_width(input int ways);
    return (ways > 1) ? log2c(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_assoc_controller_lru.sv
`default_nettype none
// ============================================================================
// Module   : dcache_assoc_controller_lru
// Purpose  : True-LRU age update and victim selection for a single set.
//            Age 0 is most recently used, NUM_WAYS-1 least recently used.
// Ports    : valid    in  NUM_WAYS        valid bits of the set
//            ages_in  in  NUM_WAYS*AGE_W  current packed ages (way 0 in LSBs)
//            acc_way  in  AGE_W           way being accessed
//            acc_fill in  1               access is a line fill
//            ages_out out NUM_WAYS*AGE_W  ages after the access
//            victim   out AGE_W           replacement victim for a miss
// Revision : 1.0 - initial release
// ============================================================================
module dcache_assoc_controller_lru
  import dcache_assoc_controller_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int AGE_W    = age_width(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0]       valid,
  input  logic [NUM_WAYS*AGE_W-1:0] ages_in,
  input  logic [AGE_W-1:0]          acc_way,
  input  logic                      acc_fill,
  output logic [NUM_WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]          victim
);

  localparam logic [AGE_W-1:0] OLDEST = AGE_W'(NUM_WAYS - 1);

  logic [AGE_W-1:0] acc_age;
  logic [AGE_W-1:0] age_w;

  always_comb begin
    // A fill behaves like touching the oldest slot, so every valid
    // younger way ages by one.
    acc_age = OLDEST;
    if (!acc_fill) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == acc_way) acc_age = ages_in[w*AGE_W +: AGE_W];
      end
    end

    ages_out = ages_in;
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_w = ages_in[w*AGE_W +: AGE_W];
      if (AGE_W'(w) == acc_way) begin
        ages_out[w*AGE_W +: AGE_W] = '0;
      end else if (valid[w] && (age_w < acc_age)) begin
        ages_out[w*AGE_W +: AGE_W] = age_w + AGE_W'(1);
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages_in[w*AGE_W +: AGE_W] == OLDEST) victim = AGE_W'(w);
    end
    // An invalid way always wins over the LRU way; lowest index first.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AGE_W'(w);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_assoc_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_assoc_controller
// Purpose  : N-way set-associative write-back / write-allocate data cache
//            controller with true-LRU replacement, between the MEM stage and
//            a line-wide external memory. Stalls the pipeline on a miss.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            cpu_addr_i/cpu_data_i   request byte address and store data
//            cpu_MemRead_i/Write_i   level requests (write has priority)
//            cpu_data_o/cpu_stall_o  load data, pipeline freeze
//            mem_enable_o/write_o    memory request, 1 = write-back
//            mem_addr_o/mem_data_o   line address, victim line
//            mem_data_i/mem_ack_i    fill line, one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module dcache_assoc_controller
  import dcache_assoc_controller_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int LINE_W   = 256,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFF_W  = log2c(LINE_W / 8);
  localparam int IDX_W  = log2c(NUM_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W  = age_width(NUM_WAYS);
  localparam int WOFF_W = log2c(WORD_W / 8);
  localparam int WSEL_W = OFF_W - WOFF_W;
  localparam int WORDS  = LINE_W / WORD_W;

  // Storage arrays indexed [set][way]
  logic [TAG_W-1:0]          tag_mem   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]         data_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]       valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0]       dirty_mem [NUM_SETS];
  logic [NUM_WAYS*AGE_W-1:0] age_mem   [NUM_SETS];

  state_t            state;
  logic [AGE_W-1:0]  victim_r;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;

  // Request decode
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              req_any;
  logic              unused_addr_bits;

  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_wsel         = cpu_addr_i[WOFF_W +: WSEL_W];
  assign req_any          = cpu_MemRead_i | cpu_MemWrite_i;
  assign unused_addr_bits = ^cpu_addr_i[WOFF_W-1:0];

  // Tag compare across all ways of the addressed set
  logic [NUM_WAYS-1:0] hit_vec;
  logic [AGE_W-1:0]    hit_way;
  logic                way_hit;
  logic                idle_hit;
  logic                write_hit;
  logic                fill_done;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AGE_W'(w);
    end
  end

  assign way_hit   = |hit_vec;
  assign idle_hit  = (state == ST_IDLE) && req_any && way_hit;
  assign write_hit = idle_hit && cpu_MemWrite_i;
  assign fill_done = (state == ST_FILL) && mem_enable_o && mem_ack_i;

  // Word select for loads and word merge for stores
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged_line;
  logic [WORD_W-1:0] hit_word;

  assign hit_line = data_mem[req_idx][hit_way];

  always_comb begin
    hit_word    = '0;
    merged_line = hit_line;
    for (int k = 0; k < WORDS; k++) begin
      if (WSEL_W'(k) == req_wsel) begin
        hit_word                        = hit_line[k*WORD_W +: WORD_W];
        merged_line[k*WORD_W +: WORD_W] = cpu_data_i;
      end
    end
  end

  assign cpu_data_o  = idle_hit ? hit_word : '0;
  assign cpu_stall_o = (state != ST_IDLE) || (req_any && !way_hit);

  // LRU: during IDLE the request's set and hit way are updated; outside
  // IDLE the only update is the fill into the latched victim.
  logic [IDX_W-1:0]          lru_idx;
  logic [AGE_W-1:0]          lru_acc_way;
  logic [NUM_WAYS*AGE_W-1:0] lru_ages_out;
  logic [AGE_W-1:0]          lru_victim;

  assign lru_idx     = (state == ST_IDLE) ? req_idx : miss_idx;
  assign lru_acc_way = (state == ST_IDLE) ? hit_way : victim_r;

  dcache_assoc_controller_lru #(
    .NUM_WAYS (NUM_WAYS),
    .AGE_W    (AGE_W)
  ) u_lru (
    .valid    (valid_mem[lru_idx]),
    .ages_in  (age_mem[lru_idx]),
    .acc_way  (lru_acc_way),
    .acc_fill (state != ST_IDLE),
    .ages_out (lru_ages_out),
    .victim   (lru_victim)
  );

  // Controller FSM with registered memory-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      victim_r     <= '0;
      miss_idx     <= '0;
      miss_tag     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any && !way_hit) begin
            victim_r     <= lru_victim;
            miss_idx     <= req_idx;
            miss_tag     <= req_tag;
            mem_enable_o <= 1'b1;
            if (valid_mem[req_idx][lru_victim] && dirty_mem[req_idx][lru_victim]) begin
              state       <= ST_WB;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_mem[req_idx][lru_victim], req_idx, {OFF_W{1'b0}}};
              mem_data_o  <= data_mem[req_idx][lru_victim];
            end else begin
              state       <= ST_FILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WB: begin
          // Enter FILL with the request dropped: one idle bus cycle between requests.
          if (mem_ack_i) begin
            state        <= ST_FILL;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (!mem_enable_o) begin
            mem_enable_o <= 1'b1;
            mem_addr_o   <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
          end else if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Valid / dirty / age bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        age_mem[s]   <= '0;
      end
    end else begin
      if (idle_hit) begin
        age_mem[req_idx] <= lru_ages_out;
      end
      if (write_hit) begin
        dirty_mem[req_idx][hit_way] <= 1'b1;
      end
      if (fill_done) begin
        valid_mem[miss_idx][victim_r] <= 1'b1;
        dirty_mem[miss_idx][victim_r] <= 1'b0;
        age_mem[miss_idx]             <= lru_ages_out;
      end
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (write_hit) begin
      data_mem[req_idx][hit_way] <= merged_line;
    end
    if (fill_done) begin
      data_mem[miss_idx][victim_r] <= mem_data_i;
      tag_mem[miss_idx][victim_r]  <= miss_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_assoc_controller
// Purpose  : Self-checking bench for dcache_assoc_controller. A 2-way
//            instance and a direct-mapped instance share the CPU request
//            inputs; each has its own memory responder. Only one instance
//            is out of reset at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_assoc_controller;

  localparam int LAT_A = 10;
  localparam int LAT_B = 3;
  localparam int TMO   = 200;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_fills;
    int          exp_wbs;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_w1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;

  logic [31:0]  data_a, maddr_a;
  logic         stall_a, men_a, mwr_a;
  logic [255:0] mdata_a;
  logic [255:0] mrd_a = '0;
  logic         ack_a = 1'b0;

  logic [31:0]  data_b, maddr_b;
  logic         stall_b, men_b, mwr_b;
  logic [255:0] mdata_b_unused;
  logic [255:0] mrd_b = '0;
  logic         ack_b = 1'b0;

  dcache_assoc_controller #(.NUM_WAYS(2)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
    .cpu_data_o(data_a), .cpu_stall_o(stall_a),
    .mem_enable_o(men_a), .mem_write_o(mwr_a),
    .mem_addr_o(maddr_a), .mem_data_o(mdata_a),
    .mem_data_i(mrd_a), .mem_ack_i(ack_a)
  );

  dcache_assoc_controller #(.NUM_WAYS(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
    .cpu_data_o(data_b), .cpu_stall_o(stall_b),
    .mem_enable_o(men_b), .mem_write_o(mwr_b),
    .mem_addr_o(maddr_b), .mem_data_o(mdata_b_unused),
    .mem_data_i(mrd_b), .mem_ack_i(ack_b)
  );

  // Background memory content: word k of line L = 0x5000_0000 | L<<8 | k
  function automatic logic [255:0] pattern_line(input int line);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h5000_0000 | 32'(line << 8) | 32'(k);
    return l;
  endfunction

  logic [255:0] mem_a [64];
  int           cnt_a = 0, fills_a = 0, wbs_a = 0;
  logic [31:0]  last_fill_a = '0, last_wb_a = '0, last_wbw1_a = '0;
  int           cnt_b = 0, fills_b = 0;
  logic [31:0]  last_fill_b = '0;

  // Responders: ack is raised in the LAT-th cycle of a request
  always @(negedge clk) begin
    if (men_a) begin
      cnt_a = cnt_a + 1;
      if (cnt_a == LAT_A) begin
        ack_a = 1'b1;
        if (mwr_a) begin
          mem_a[maddr_a[10:5]] = mdata_a;
          wbs_a       = wbs_a + 1;
          last_wb_a   = maddr_a;
          last_wbw1_a = mdata_a[63:32];
        end else begin
          mrd_a       = mem_a[maddr_a[10:5]];
          fills_a     = fills_a + 1;
          last_fill_a = maddr_a;
        end
      end else begin
        ack_a = 1'b0;
      end
    end else begin
      cnt_a = 0;
      ack_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (men_b && !mwr_b) begin
      cnt_b = cnt_b + 1;
      if (cnt_b == LAT_B) begin
        ack_b       = 1'b1;
        mrd_b       = pattern_line(int'(maddr_b[10:5]));
        fills_b     = fills_b + 1;
        last_fill_b = maddr_b;
      end else begin
        ack_b = 1'b0;
      end
    end else begin
      cnt_b = 0;
      ack_b = 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access: drive at negedge, count stalled cycles, sample data when released.
  task automatic do_access(input int which, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    stalls = 0;
    while (((which == 0) ? stall_a : stall_b) && stalls < TMO) begin
      stalls = stalls + 1;
      @(negedge clk);
      #1;
    end
    rdata = (which == 0) ? data_a : data_b;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic run_vec(input int which, input int idx, input vec_t v);
    int f0, w0, st;
    logic [31:0] rd;
    string nm;
    f0 = (which == 0) ? fills_a : fills_b;
    w0 = wbs_a;
    do_access(which, v.wr, v.rd, v.addr, v.wdata, st, rd);
    nm = $sformatf("%s%0d", (which == 0) ? "a" : "b", idx);
    check({nm, "_stall"}, 64'(st), 64'(v.exp_stall));
    if (v.chk_data) check({nm, "_data"}, 64'(rd), 64'(v.exp_data));
    check({nm, "_fills"}, 64'(((which == 0) ? fills_a : fills_b) - f0), 64'(v.exp_fills));
    if (which == 0) check({nm, "_wbs"}, 64'(wbs_a - w0), 64'(v.exp_wbs));
    if (v.exp_fills > 0)
      check({nm, "_fill_addr"}, 64'((which == 0) ? last_fill_a : last_fill_b),
            64'(v.addr & 32'hFFFF_FFE0));
    if (v.exp_wbs > 0) begin
      check({nm, "_wb_addr"}, 64'(last_wb_a), 64'(v.exp_wb_addr));
      check({nm, "_wb_word1"}, 64'(last_wbw1_a), 64'(v.exp_wb_w1));
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk,
                              input logic [31:0] exp_data, input int st,
                              input int fills, input int wbs,
                              input logic [31:0] wb_addr, input logic [31:0] wb_w1);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.chk_data = chk; v.exp_data = exp_data; v.exp_stall = st;
    v.exp_fills = fills; v.exp_wbs = wbs; v.exp_wb_addr = wb_addr; v.exp_wb_w1 = wb_w1;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va[$];
    vec_t vb[$];
    vec_t v4;

    for (int i = 0; i < 64; i++) mem_a[i] = pattern_line(i);
    mem_a[32][31:0] = 32'hDEAD_BEEF;

    // Clean miss = LAT_A+2 stalled cycles, dirty miss = 2*LAT_A+3.
    va.push_back(mk(0, 1, 32'h400, 0,            1, 32'hDEAD_BEEF, 12, 1, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h400, 0,            1, 32'hDEAD_BEEF,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h000, 0,            1, 32'h5000_0000, 12, 1, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h200, 0,            1, 32'h5000_1000, 12, 1, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h000, 0,            1, 32'h5000_0000,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h400, 0,            1, 32'hDEAD_BEEF, 12, 1, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h000, 0,            1, 32'h5000_0000,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h200, 0,            1, 32'h5000_1000, 12, 1, 0, 0, 0));
    va.push_back(mk(1, 0, 32'h004, 32'h1234_5678, 0, 0,             0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h004, 0,            1, 32'h1234_5678,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h200, 0,            1, 32'h5000_1000,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h400, 0,            1, 32'hDEAD_BEEF, 23, 1, 1, 32'h000, 32'h1234_5678));
    va.push_back(mk(0, 1, 32'h004, 0,            1, 32'h1234_5678, 12, 1, 0, 0, 0));
    va.push_back(mk(1, 0, 32'h408, 32'hCAFE_F00D, 0, 0,             0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h408, 0,            1, 32'hCAFE_F00D,  0, 0, 0, 0, 0));
    va.push_back(mk(1, 1, 32'h40C, 32'h0BAD_F00D, 0, 0,             0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h40C, 0,            1, 32'h0BAD_F00D,  0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 32'h024, 0,            1, 32'h5000_0101, 12, 1, 0, 0, 0));

    vb.push_back(mk(0, 1, 32'h000, 0, 1, 32'h5000_0000, 5, 1, 0, 0, 0));
    vb.push_back(mk(0, 1, 32'h200, 0, 1, 32'h5000_1000, 5, 1, 0, 0, 0));
    vb.push_back(mk(0, 1, 32'h000, 0, 1, 32'h5000_0000, 5, 1, 0, 0, 0));

    // Reset state
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("rst_stall",   64'(stall_a), 64'd0);
    check("rst_data",    64'(data_a),  64'd0);
    check("rst_men",     64'(men_a),   64'd0);
    check("rst_mwr",     64'(mwr_a),   64'd0);
    check("rst_maddr",   64'(maddr_a), 64'd0);
    check("rst_mdata",   64'(|mdata_a), 64'd0);

    foreach (va[i]) run_vec(0, i, va[i]);

    // Reset pulsed in the middle of a fill
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h200;
    repeat (3) @(negedge clk);
    #1;
    check("t4_fill_en",   64'(men_a),   64'd1);
    check("t4_fill_wr",   64'(mwr_a),   64'd0);
    check("t4_fill_addr", 64'(maddr_a), 64'h200);
    @(negedge clk);
    rst_a = 1'b1; cpu_rd = 1'b0;
    @(negedge clk);
    #1;
    check("t4_rst_men",   64'(men_a),   64'd0);
    check("t4_rst_stall", 64'(stall_a), 64'd0);
    rst_a = 1'b0;
    v4 = mk(0, 1, 32'h400, 0, 1, 32'hDEAD_BEEF, 12, 1, 0, 0, 0);
    run_vec(0, 100, v4);

    // A miss request withdrawn before the edge starts nothing
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h600;
    #1;
    check("wd_stall_comb", 64'(stall_a), 64'd1);
    #2;
    cpu_rd = 1'b0;
    @(negedge clk);
    #1;
    check("wd_men",   64'(men_a),   64'd0);
    check("wd_stall", 64'(stall_a), 64'd0);

    // Direct-mapped build
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b0;
    foreach (vb[i]) run_vec(1, i, vb[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
